// File: rtl/fsmc_pkg.sv
// ============================================================================
// Module : fsmc_pkg
// Brief  : Shared widths, default bus timings, state encoding and helpers
//          for the FSMC-style multiplexed bus master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsmc_pkg;

    localparam int AD_W   = 18;
    localparam int DATA_W = 16;

    localparam int unsigned ADDSET_DEF  = 5;
    localparam int unsigned ADDHLD_DEF  = 4;
    localparam int unsigned DATAST_DEF  = 10;
    localparam int unsigned DHOLD_DEF   = 3;
    localparam int unsigned BUSTURN_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AHOLD = 3'd2,
        ST_DATA  = 3'd3,
        ST_DHOLD = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    // Timer reload value for a phase of 'cycles' length; 0 is treated as 1.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        if (cycles <= 1)
            return 8'd0;
        else if (cycles >= 256)
            return 8'd255;
        return 8'(cycles - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fsmc_phase_timer.sv
// ============================================================================
// Module : fsmc_phase_timer
// Brief  : 8-bit loadable down-counter with hold; tc is high at count zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsmc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       hold,
    output logic       tc
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= 8'd0;
        else if (load)
            count <= load_val;
        else if (!hold && count != 8'd0)
            count <= count - 8'd1;
    end

    assign tc = (count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/fsmc_master.sv
// ============================================================================
// Module : fsmc_master
// Brief  : Multiplexed-AD asynchronous bus master (NADV/NWE/NOE strobes).
//          Optional wait input enabled by defining FSMC_MASTER_NWAIT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsmc_master
    import fsmc_pkg::*;
#(
    parameter int unsigned ADDSET  = ADDSET_DEF,
    parameter int unsigned ADDHLD  = ADDHLD_DEF,
    parameter int unsigned DATAST  = DATAST_DEF,
    parameter int unsigned DHOLD   = DHOLD_DEF,
    parameter int unsigned BUSTURN = BUSTURN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [AD_W-1:0]   addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              NADV,
    output logic              NWE,
    output logic              NOE,
    output logic [AD_W-1:0]   ad_o,
    output logic              ad_oe,
    input  logic [AD_W-1:0]   ad_i
`ifdef FSMC_MASTER_NWAIT_EN
    ,
    input  logic              NWAIT
`endif
);

    state_t            state;
    state_t            next_state;
    logic              wr_q;
    logic [AD_W-1:0]   addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              hold;
    logic              tc;
    logic              phase_end;
    logic              load;
    logic [7:0]        load_val;
    logic [AD_W-1:0]   txn_addr;
    logic [AD_W-1:0]   txn_data;
    logic              nadv_d;
    logic              nwe_d;
    logic              noe_d;
    logic              oe_d;
    logic [AD_W-1:0]   ad_d;
    logic              unused_ad_hi;

    assign ready     = (state == ST_IDLE);
    assign accept    = ready && req;
    assign txn_addr  = accept ? addr : addr_q;
    assign txn_data  = {{(AD_W-DATA_W){1'b0}}, wdata_q};
    assign unused_ad_hi = ^ad_i[AD_W-1:DATA_W];

`ifdef FSMC_MASTER_NWAIT_EN
    logic [1:0] nwait_sync;

    always_ff @(posedge clk) begin
        if (reset)
            nwait_sync <= 2'b11;
        else
            nwait_sync <= {nwait_sync[0], NWAIT};
    end

    // A low wait level only stretches the data strobe phase.
    assign hold = (state == ST_DATA) && !nwait_sync[1];
`else
    assign hold = 1'b0;
`endif

    assign phase_end = tc && !hold;
    assign load      = (next_state != state);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req)       next_state = ST_ADDR;
            ST_ADDR:  if (phase_end) next_state = ST_AHOLD;
            ST_AHOLD: if (phase_end) next_state = ST_DATA;
            ST_DATA:  if (phase_end) next_state = ST_DHOLD;
            ST_DHOLD: if (phase_end) next_state = ST_TURN;
            ST_TURN:  if (phase_end) next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        load_val = 8'd0;
        case (next_state)
            ST_ADDR:  load_val = phase_load(ADDSET);
            ST_AHOLD: load_val = phase_load(ADDHLD);
            ST_DATA:  load_val = phase_load(DATAST);
            ST_DHOLD: load_val = phase_load(DHOLD);
            ST_TURN:  load_val = phase_load(BUSTURN);
            default:  load_val = 8'd0;
        endcase
    end

    // Strobe/AD values are decoded from next_state so the registered pins line up with state.
    always_comb begin
        nadv_d = 1'b1;
        nwe_d  = 1'b1;
        noe_d  = 1'b1;
        oe_d   = 1'b0;
        ad_d   = '0;
        case (next_state)
            ST_ADDR: begin
                nadv_d = 1'b0;
                oe_d   = 1'b1;
                ad_d   = txn_addr;
            end
            ST_AHOLD: begin
                ad_d = txn_addr;
                oe_d = wr_q || (state != ST_AHOLD);
            end
            ST_DATA: begin
                if (wr_q) begin
                    nwe_d = 1'b0;
                    oe_d  = 1'b1;
                    ad_d  = txn_data;
                end else begin
                    noe_d = 1'b0;
                end
            end
            ST_DHOLD: begin
                if (wr_q) begin
                    oe_d = 1'b1;
                    ad_d = txn_data;
                end
            end
            default: begin
                oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            NADV    <= 1'b1;
            NWE     <= 1'b1;
            NOE     <= 1'b1;
            ad_oe   <= 1'b0;
            ad_o    <= '0;
            done    <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state  <= next_state;
            NADV   <= nadv_d;
            NWE    <= nwe_d;
            NOE    <= noe_d;
            ad_oe  <= oe_d;
            ad_o   <= ad_d;
            done   <= (state == ST_DHOLD) && phase_end;
            rvalid <= (state == ST_DATA) && phase_end && !wr_q;
            if (accept) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if ((state == ST_DATA) && phase_end && !wr_q)
                rdata <= ad_i[DATA_W-1:0];
        end
    end

    fsmc_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .hold     (hold),
        .tc       (tc)
    );

endmodule

`default_nettype wire

// File: tb/tb_fsmc_master.sv
// ============================================================================
// Module : tb_fsmc_master
// Brief  : Self-checking bench for fsmc_master (default and minimum timings).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fsmc_master;
    import fsmc_pkg::*;

    typedef struct packed {
        logic        nadv;
        logic        nwe;
        logic        noe;
        logic        ad_oe;
        logic [17:0] ad_o;
        logic        ready;
        logic        done;
        logic        rvalid;
    } pins_t;

    typedef struct {
        int          s;
        logic        w;
        logic [17:0] a;
        logic [15:0] wd;
        logic [15:0] rsp;
        logic [15:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] resp_val;
    logic        ready [2];
    logic        done  [2];
    logic        rvalid[2];
    logic        nadv  [2];
    logic        nwe   [2];
    logic        noe   [2];
    logic        ad_oe [2];
    logic [17:0] ad_o  [2];
    logic [17:0] ad_i  [2];
    logic [15:0] rdata [2];
    logic [15:0] last_rd[2];
`ifdef FSMC_MASTER_NWAIT_EN
    logic        nwait = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;
    // raw parameter values of each instance; 0 must act as 1
    int unsigned prm[2][5] = '{'{5, 4, 10, 3, 2}, '{1, 1, 0, 1, 0}};

    always #5 clk = ~clk;

    // Bus responder: drives the read value only while NOE is low.
    assign ad_i[0] = !noe[0] ? {2'b00, resp_val} : 18'h2AAAA;
    assign ad_i[1] = !noe[1] ? {2'b00, resp_val} : 18'h2AAAA;

    fsmc_master u_dut (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
        .NADV(nadv[0]), .NWE(nwe[0]), .NOE(noe[0]), .ad_o(ad_o[0]), .ad_oe(ad_oe[0]),
        .ad_i(ad_i[0])
`ifdef FSMC_MASTER_NWAIT_EN
        , .NWAIT(nwait)
`endif
    );

    fsmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(0), .DHOLD(1), .BUSTURN(0)) u_dut_min (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
        .NADV(nadv[1]), .NWE(nwe[1]), .NOE(noe[1]), .ad_o(ad_o[1]), .ad_oe(ad_oe[1]),
        .ad_i(ad_i[1])
`ifdef FSMC_MASTER_NWAIT_EN
        , .NWAIT(1'b1)
`endif
    );

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if ((!nwe[i] && !noe[i]) || (!nadv[i] && (!nwe[i] || !noe[i])) || (ad_oe[i] && !noe[i]))
                viol++;
        end
    end

    function automatic int eff(input int unsigned p);
        return (p == 0) ? 1 : int'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected pins k cycles after the accepting edge, from phase boundaries e1..e5.
    function automatic pins_t model(input int k, input int e1, input int e2, input int e3,
                                    input int e4, input int e5, input logic w,
                                    input logic [17:0] a, input logic [15:0] wd);
        pins_t x;
        x = '0;
        x.nadv = 1'b1; x.nwe = 1'b1; x.noe = 1'b1;
        if (k <= e1) begin
            x.nadv = 1'b0; x.ad_oe = 1'b1; x.ad_o = a;
        end else if (k <= e2) begin
            x.ad_o = a; x.ad_oe = w || (k == e1 + 1);
        end else if (k <= e3) begin
            if (w) begin x.nwe = 1'b0; x.ad_oe = 1'b1; x.ad_o = {2'b00, wd}; end
            else   x.noe = 1'b0;
        end else if (k <= e4) begin
            if (w) begin x.ad_oe = 1'b1; x.ad_o = {2'b00, wd}; end
            x.rvalid = !w && (k == e3 + 1);
        end else if (k <= e5) begin
            x.done = (k == e4 + 1);
        end else begin
            x.ready = 1'b1;
        end
        return x;
    endfunction

    task automatic run_txn(input int s, input logic w, input logic [17:0] a, input logic [15:0] wd,
                           input logic [15:0] rsp, input int ext, input logic keep,
                           output int waited, output int noe_lo);
        int e1, e2, e3, e4, e5, busy, dn, rv;
        pins_t act, exp;
        logic care;
        e1 = eff(prm[s][0]);
        e2 = e1 + eff(prm[s][1]);
        e3 = e2 + eff(prm[s][2]) + ext;
        e4 = e3 + eff(prm[s][3]);
        e5 = e4 + eff(prm[s][4]);
        waited = 0; noe_lo = 0; busy = 0; dn = 0; rv = 0;
        while (ready[s] !== 1'b1 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (ready[s] !== 1'b1) begin
            check("ready_timeout", 64'(ready[s]), 64'd1);
            return;
        end
        wr = w; addr = a; wdata = wd; resp_val = rsp; req[s] = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) req[s] = 1'b0;
        for (int k = 1; k <= e5 + 1; k++) begin
            @(negedge clk);
`ifdef FSMC_MASTER_NWAIT_EN
            if (ext > 0) nwait = !(k >= e2 + 2 && k < e2 + 2 + ext);
`endif
            exp  = model(k, e1, e2, e3, e4, e5, w, a, wd);
            act  = {nadv[s], nwe[s], noe[s], ad_oe[s], ad_o[s], ready[s], done[s], rvalid[s]};
            care = exp.ad_oe || (k > e1 && k <= e2);
            if (!care) begin act.ad_o = '0; exp.ad_o = '0; end
            check($sformatf("pins_dut%0d_k%0d", s, k), 64'(act), 64'(exp));
            if (!ready[s]) busy++;
            if (done[s]) dn++;
            if (rvalid[s]) rv++;
            if (!noe[s]) noe_lo++;
        end
`ifdef FSMC_MASTER_NWAIT_EN
        nwait = 1'b1;
`endif
        if (!w) last_rd[s] = rsp;
        check($sformatf("busy_cycles_dut%0d", s), 64'(busy), 64'(e5));
        check($sformatf("done_pulses_dut%0d", s), 64'(dn), 64'd1);
        check($sformatf("rvalid_pulses_dut%0d", s), 64'(rv), w ? 64'd0 : 64'd1);
        check($sformatf("rdata_dut%0d", s), 64'(rdata[s]), 64'(last_rd[s]));
    endtask

    vec_t vecs[6];

    initial begin
        int wt, nl, dn, rv;
        vecs[0] = '{0, 1'b1, 18'h10000, 16'h0F0F, 16'h0000, 16'h0000};
        vecs[1] = '{0, 1'b0, 18'h10000, 16'h0000, 16'h2321, 16'h2321};
        vecs[2] = '{0, 1'b1, 18'h3FFFF, 16'hFFFF, 16'h0000, 16'h2321};
        vecs[3] = '{1, 1'b0, 18'h00000, 16'h0000, 16'hA5C3, 16'hA5C3};
        vecs[4] = '{1, 1'b1, 18'h2AAAA, 16'h5555, 16'h0000, 16'hA5C3};
        vecs[5] = '{1, 1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF, 16'hFFFF};

        reset = 1'b1; req = 2'b00; wr = 1'b0; addr = '0; wdata = '0; resp_val = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_pins_dut%0d", i),
                  64'({nadv[i], nwe[i], noe[i], ad_oe[i], ad_o[i], ready[i], done[i], rvalid[i]}),
                  64'({1'b1, 1'b1, 1'b1, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0}));
            check($sformatf("reset_rdata_dut%0d", i), 64'(rdata[i]), 64'd0);
        end

        foreach (vecs[v]) begin
            run_txn(vecs[v].s, vecs[v].w, vecs[v].a, vecs[v].wd, vecs[v].rsp, 0, 1'b0, wt, nl);
            check($sformatf("vec%0d_rdata", v), 64'(rdata[vecs[v].s]), 64'(vecs[v].exp_rdata));
        end

        // Back-to-back with req held: write then read, no idle gap.
        run_txn(0, 1'b1, 18'h0ABCD, 16'h1234, 16'h0000, 0, 1'b1, wt, nl);
        run_txn(0, 1'b0, 18'h0ABCE, 16'h0000, 16'h4321, 0, 1'b0, wt, nl);
        check("b2b_wait_cycles", 64'(wt), 64'd0);
        run_txn(1, 1'b0, 18'h01111, 16'h0000, 16'h0F1E, 0, 1'b1, wt, nl);
        run_txn(1, 1'b1, 18'h02222, 16'hC0DE, 16'h0000, 0, 1'b0, wt, nl);
        check("b2b_min_wait_cycles", 64'(wt), 64'd0);

        for (int r = 0; r < 24; r++) begin
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom),
                    16'($urandom), 16'($urandom), 0, 1'b0, wt, nl);
        end

`ifdef FSMC_MASTER_NWAIT_EN
        run_txn(0, 1'b0, 18'h10000, 16'h0000, 16'h7E81, 6, 1'b0, wt, nl);
        check("nwait_noe_low_cycles", 64'(nl), 64'(eff(prm[0][2]) + 6));
        check("nwait_rdata", 64'(rdata[0]), 64'h7E81);
`endif

        // Reset in the 5th DATA cycle of a write aborts it.
        @(negedge clk);
        wr = 1'b1; addr = 18'h155AA; wdata = 16'hBEEF; req[0] = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0;
        repeat (eff(prm[0][0]) + eff(prm[0][1]) + 5) @(negedge clk);
        check("abort_nwe_before", 64'(nwe[0]), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_pins", 64'({nadv[0], nwe[0], noe[0], ad_oe[0], ready[0], done[0]}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}));
        dn = 0; rv = 0;
        repeat (30) begin
            @(negedge clk);
            if (done[0]) dn++;
            if (rvalid[0]) rv++;
        end
        check("abort_done_pulses", 64'(dn), 64'd0);
        check("abort_rvalid_pulses", 64'(rv), 64'd0);
        check("abort_rdata_cleared", 64'(rdata[1]), 64'd0);
        check("invariant_violations", 64'(viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsmc_master.md
FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 Parameter ADDSET, default 5: cycles NADV is held low with the address on AD, range 1..255.
REQ-002 Parameter ADDHLD, default 4: cycles the address is held after NADV rises, range 1..255.
REQ-003 Parameter DATAST, default 10: cycles NWE or NOE is held low, range 1..255.
REQ-004 Parameter DHOLD, default 3: cycles write data is held after NWE rises, range 1..255.
REQ-005 Parameter BUSTURN, default 2: idle cycles after each transaction before ready reasserts, range 1..255.
REQ-006 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: synchronous reset, active-high.
REQ-008 Port req, input, 1: transaction request.
REQ-009 Port wr, input, 1: 1 = write, 0 = read; sampled with req.
REQ-010 Port addr, input, 18: bus address; sampled with req.
REQ-011 Port wdata, input, 16: write data; sampled with req.
REQ-012 Port ready, output, 1: high only in IDLE; a request is accepted when req and ready are both high.
REQ-013 Port done, output, 1: one-cycle pulse when a transaction leaves DHOLD.
REQ-014 Port rdata, output, 16: captured read data.
REQ-015 Port rvalid, output, 1: one-cycle pulse when rdata updates.
REQ-016 Ports NADV, NWE and NOE, outputs, 1 each: active-low bus strobes, all registered.
REQ-017 Port ad_o, output, 18: AD drive value.
REQ-018 Port ad_oe, output, 1: AD drive enable; the top level forms AD = ad_oe ? ad_o : 'z.
REQ-019 Port ad_i, input, 18: sampled AD value.

Function
REQ-020 State sequence: IDLE -> ADDR -> AHOLD -> DATA -> DHOLD -> TURN -> IDLE.
- Each state lasts exactly its parameter count: ADDSET, ADDHLD, DATAST, DHOLD, BUSTURN.
REQ-021 Acceptance latches wr, addr and wdata, and enters ADDR on the next edge.
- req while not ready is ignored; it is not queued.
REQ-022 ADDR: NADV=0, ad_oe=1, ad_o=addr.
REQ-023 AHOLD: NADV=1 and ad_o=addr.
- Write: ad_oe=1.
- Read: ad_oe=1 for the first cycle, then 0 (turnaround before NOE).
REQ-024 DATA, write: NWE=0, ad_oe=1, ad_o = {2'b00, wdata}.
REQ-025 DATA, read: NOE=0, ad_oe=0.
- rdata <= ad_i[15:0] on the final DATA cycle.
- rvalid pulses in the first DHOLD cycle.
REQ-026 DHOLD: all strobes are 1.
- Write: ad_oe=1 with data held.
- Read: ad_oe=0.
REQ-027 TURN: strobes are 1 and ad_oe=0.
REQ-028 Total cycles from acceptance to ready reasserting = ADDSET + ADDHLD + DATAST + DHOLD + BUSTURN.
REQ-029 Invariants, held on every cycle:
- NWE and NOE are never both 0.
- NADV is never 0 while NWE or NOE is 0.
- ad_oe is never 1 while NOE is 0.
REQ-030 With req held high, the next request is accepted in the first IDLE cycle; there are no extra idle cycles.
REQ-031 A parameter value of 0 behaves as 1.
REQ-032 rdata holds its value until the next read completes.

Reset
REQ-033 On reset the block takes these values at the next edge:
- state=IDLE.
- NADV=NWE=NOE=1, ad_oe=0, ad_o=0.
- ready=1, done=0, rvalid=0, rdata=0.
REQ-034 Reset mid-transaction aborts it at once: no done and no rvalid, and the strobes go high within one cycle.

Configuration
REQ-035 With FSMC_MASTER_NWAIT_EN defined:
- Input NWAIT (1 bit, active-low) is present and passes through a 2-flop synchronizer.
- In DATA, the synchronized NWAIT=0 freezes the DATAST counter, extending the strobe one cycle per low cycle.
REQ-036 Without FSMC_MASTER_NWAIT_EN: no NWAIT port, and DATA is always exactly DATAST cycles.

Structure
REQ-037 Package fsmc_pkg SHALL hold:
- the state enum;
- the widths AD_W=18 and DATA_W=16;
- the default timing constants.
REQ-038 One sub-module, fsmc_phase_timer: an 8-bit loadable down-counter with hold input and terminal-count output, shared by all timed states.

Verification
REQ-039 Write addr=0x10000, wdata=0x0F0F:
- NADV low 5 cycles with AD=0x10000.
- NWE low 10 cycles with AD=0x00F0F.
- done pulses once; ready returns after exactly 24 cycles.
REQ-040 Read addr=0x10000, responder drives 0x2321 while NOE=0:
- AD is released before NOE falls.
- rdata=0x2321 and rvalid pulses once.
REQ-041 req held high with a write then a read: the second request is accepted on the first cycle ready=1; no overlap of strobes.
REQ-042 reset asserted in the 5th DATA cycle of a write:
- next cycle NWE=1, ad_oe=0, ready=1;
- no done pulse.
REQ-043 FSMC_MASTER_NWAIT_EN defined, NWAIT low 6 cycles during a read: NOE low for 16 cycles and rdata is correct.
REQ-044 Assertions for REQ-029 run throughout all scenarios with zero failures, including all parameters set to 1.
